aes_key_expand: RTL and testbench
=================================

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 The block SHALL have no parameters; AES-128 only, with a fixed 10-round schedule.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin expansion; sampled only in IDLE.
REQ-005 key  input  128  cipher key; word0 SHALL be at [31:0], word1 at [63:32], word2 at [95:64], word3 at [127:96]; byte0 of each word SHALL be at its [31:24].
REQ-006 round_key  output  128  current round key, packed exactly as key.
REQ-007 round_num  output  4  index of round_key, 0..10.
REQ-008 rk_valid  output  1  round_key and round_num are valid.
REQ-009 rk_ready  input  1  consumer accepts round_key.
REQ-010 busy  output  1  high whenever state != IDLE.
REQ-011 done  output  1  one-cycle pulse after round 10 is accepted.

Function
REQ-012 The FSM SHALL have states IDLE, OUT, SUB, GEN.
REQ-013 In IDLE with start=1, the block SHALL capture key into round_key, set round_num=0 and go to OUT at the same edge.
- rk_valid SHALL therefore be high in the cycle after the start edge.
REQ-014 In OUT, rk_valid SHALL be 1.
- While rk_ready=0, round_key and round_num SHALL hold stable.
REQ-015 An OUT cycle with rk_ready=1 is an accept.
- round_num<10: go to SUB with byte index 0.
- round_num=10: go to IDLE and assert done in the next cycle.
REQ-016 SUB SHALL use one shared 256-entry AES forward S-box, one byte per cycle, over 4 cycles.
- Inputs SHALL be the bytes of RotWord(word3) = {w3[23:0], w3[31:24]}, in order [31:24], [23:16], [15:8], [7:0].
- Each result byte SHALL be latched into a 32-bit temp register.
- After the 4th SUB edge, the FSM SHALL go to GEN.
REQ-017 At the GEN edge, the block SHALL compute:
- t = temp ^ {rcon, 24'h0}
- n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2
- It SHALL load {n3,n2,n1,n0} into round_key, increment round_num, and go to OUT.
REQ-018 rcon for next round r = 1..10 SHALL be 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 (hex).
REQ-019 Latency SHALL be: accept edge -> rk_valid high again 5 cycles later (4 SUB + 1 GEN), independent of rk_ready.
REQ-020 rk_valid SHALL be 0 in IDLE, SUB and GEN.
- round_key SHALL only change at a start edge or a GEN edge.
REQ-021 start SHALL be ignored while busy=1; key changes while busy SHALL have no effect.
REQ-022 start in the done cycle (state IDLE) SHALL be accepted normally.
- done and the new busy SHALL then both be visible for correct cycle ordering (done=1 in that cycle, busy=1 from the next).
REQ-023 All arithmetic SHALL be bitwise XOR, with no carries; round_num SHALL never exceed 10.

Reset
REQ-024 While rst=1, the block SHALL hold state=IDLE and all of the following at 0:
- round_key, round_num, temp and byte index
- rk_valid, busy and done
REQ-025 Reset asserted mid-expansion (any state) SHALL abort immediately with no done pulse.
- The next start after release SHALL begin again at round 0.

Verification
REQ-026 FIPS-197 key: key=128'h09cf4f3c_abf71588_28aed2a6_2b7e1516, start, rk_ready=1 ->
- round 0 equals key
- round 1 = 128'h2a6c7605_23a33939_88542cb1_a0fafe17
- round 10 = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8
- done pulses once.
REQ-027 Backpressure: hold rk_ready=0 for 20 cycles at round 3 -> round_key and round_num=3 stay stable, rk_valid stays 1, round 4 key is still correct after release.
REQ-028 Timing: with rk_ready=1 constant ->
- rk_valid at 1 cycle after start, then every 6 cycles
- done exactly 1 cycle after the round 10 accept
- 11 accepts total.
REQ-029 Start while busy: pulse start with a different key at round 5 -> sequence unchanged, with no restart.
REQ-030 Reset during SUB of round 7 -> all outputs 0 next cycle, no done pulse. A subsequent start with the all-zero key SHALL give round 1 = 128'h62636363_62636363_62636363_62636363.
REQ-031 Back-to-back: start asserted in the done cycle -> new round 0 valid on the following cycle.

Source files
------------

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: emits the 11 round keys one at a time under a valid/ready
// handshake, sharing a single S-box across the four bytes of each SubWord step.
module aes_key_expand (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
   output logic [127:0] round_key,
   output logic [3:0]   round_num,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {IDLE, OUT, SUB, GEN} state_t;

   // Forward S-box, entry 0 in the most significant byte
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Round constant for the key that follows round rn
   function automatic logic [7:0] rcon_for(input logic [3:0] rn);
      logic [7:0] rc;
      case (rn)
         4'd0:    rc = 8'h01;
         4'd1:    rc = 8'h02;
         4'd2:    rc = 8'h04;
         4'd3:    rc = 8'h08;
         4'd4:    rc = 8'h10;
         4'd5:    rc = 8'h20;
         4'd6:    rc = 8'h40;
         4'd7:    rc = 8'h80;
         4'd8:    rc = 8'h1b;
         4'd9:    rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   state_t      state, next_state;
   logic [31:0] temp;
   logic [1:0]  byte_idx;
   logic [31:0] w0, w1, w2, w3, rot_word, t, n0, n1, n2, n3;
   logic [7:0]  sbox_in, sbox_out;
   logic        accept;

   assign w0       = round_key[31:0];
   assign w1       = round_key[63:32];
   assign w2       = round_key[95:64];
   assign w3       = round_key[127:96];
   assign rot_word = {w3[23:0], w3[31:24]};
   assign rk_valid = (state == OUT);
   assign busy     = (state != IDLE);
   assign accept   = (state == OUT) && rk_ready;

   always_comb begin
      sbox_in = 8'h00;
      case (byte_idx)
         2'd0: sbox_in = rot_word[31:24];
         2'd1: sbox_in = rot_word[23:16];
         2'd2: sbox_in = rot_word[15:8];
         2'd3: sbox_in = rot_word[7:0];
         default: sbox_in = 8'h00;
      endcase
   end

   assign sbox_out = SBOX[sbox_in];

   always_comb begin
      t  = temp ^ {rcon_for(round_num), 24'h000000};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start) next_state = OUT;
         OUT:  if (rk_ready) next_state = (round_num == 4'd10) ? IDLE : SUB;
         SUB:  if (byte_idx == 2'd3) next_state = GEN;
         GEN:  next_state = OUT;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         round_key <= '0;
         round_num <= '0;
         temp      <= '0;
         byte_idx  <= '0;
         done      <= 1'b0;
      end else begin
         done <= accept && (round_num == 4'd10);
         case (state)
            IDLE: begin
               if (start) begin
                  round_key <= key;
                  round_num <= 4'd0;
               end
            end
            OUT: begin
               if (rk_ready) byte_idx <= 2'd0;
            end
            SUB: begin
               case (byte_idx)
                  2'd0: temp[31:24] <= sbox_out;
                  2'd1: temp[23:16] <= sbox_out;
                  2'd2: temp[15:8]  <= sbox_out;
                  2'd3: temp[7:0]   <= sbox_out;
                  default: temp <= temp;
               endcase
               byte_idx <= byte_idx + 2'd1;
            end
            GEN: begin
               round_key <= {n3, n2, n1, n0};
               round_num <= round_num + 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: an arithmetic (GF(2^8)) key-schedule model
// predicts every round key; a monitor checks keys, handshake timing and done pulses.
module tb_aes_key_expand;

   logic         clk = 1'b0;
   logic         rst, start, rk_ready;
   logic [127:0] key;
   logic [127:0] round_key;
   logic [3:0]   round_num;
   logic         rk_valid, busy, done;

   aes_key_expand dut (
      .clk(clk), .rst(rst), .start(start), .key(key),
      .round_key(round_key), .round_num(round_num), .rk_valid(rk_valid),
      .rk_ready(rk_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]   rn;
      logic [127:0] rk;
   } exp_t;

   exp_t         sb[$];
   int           n_checks = 0, n_errors = 0;
   int           cyc = 0;
   int           exp_valid_cyc = -1, exp_done_cyc = -1;
   int           accepts = 0, done_cnt = 0;
   logic         prev_valid = 1'b0;
   logic [127:0] cap [0:10];

   localparam logic [127:0] FIPS_KEY = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
   localparam logic [127:0] FIPS_R1  = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
   localparam logic [127:0] FIPS_R10 = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
   localparam logic [127:0] ZERO_R1  = 128'h62636363_62636363_62636363_62636363;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00, aa = a, bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xtime(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      logic [15:0] d = {b, b};
      return d[15-k -: 8];
   endfunction

   // S-box as multiplicative inverse (x^254) followed by the affine map
   function automatic logic [7:0] sbox_m(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w [4];
      logic [31:0] r, s, nw [4];
      for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
      r = {w[3][23:0], w[3][31:24]};
      s = {sbox_m(r[31:24]), sbox_m(r[23:16]), sbox_m(r[15:8]), sbox_m(r[7:0])};
      nw[0] = w[0] ^ s ^ {rc, 24'h0};
      for (int i = 1; i < 4; i++) nw[i] = w[i] ^ nw[i-1];
      return {nw[3], nw[2], nw[1], nw[0]};
   endfunction

   task automatic push_expansion(input logic [127:0] k0);
      logic [127:0] k = k0;
      logic [7:0]   rc = 8'h01;
      exp_t         e;
      for (int r = 0; r <= 10; r++) begin
         e.rn = 4'(r);
         e.rk = k;
         sb.push_back(e);
         if (r < 10) begin
            k  = next_key(k, rc);
            rc = xtime(rc);
         end
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: scoreboard pushes on accepted starts, pops on accepted round keys
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
         exp_valid_cyc = -1;
         exp_done_cyc  = -1;
         prev_valid    = 1'b0;
      end else begin
         if (rk_valid && !prev_valid) check("valid_time", 128'(cyc), 128'(exp_valid_cyc));
         if (done || cyc == exp_done_cyc) begin
            check("done_time", 128'(done), 128'(cyc == exp_done_cyc));
            if (done) done_cnt++;
         end
         if (rk_valid && rk_ready) begin
            accepts++;
            if (round_num <= 4'd10) cap[round_num] = round_key;
            if (sb.size() == 0) begin
               check("sb_empty", 128'(sb.size()), 128'd1);
            end else begin
               e = sb.pop_front();
               check("round_num", 128'(round_num), 128'(e.rn));
               check("round_key", round_key, e.rk);
            end
            if (round_num == 4'd10) begin
               exp_done_cyc  = cyc + 1;
               exp_valid_cyc = -1;
            end else begin
               exp_valid_cyc = cyc + 6;
            end
         end
         if (start && !busy) begin
            push_expansion(key);
            exp_valid_cyc = cyc + 1;
         end
         prev_valid = rk_valid;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_round(input logic [3:0] r, input int budget);
      int n = 0;
      while (!(rk_valid && round_num == r) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check("wait_round", {rk_valid, round_num}, {1'b1, r});
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check("wait_done", 128'(done), 128'd1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_rk"},    round_key, 128'd0);
      check({tag, "_rn"},    128'(round_num), 128'd0);
      check({tag, "_valid"}, 128'(rk_valid), 128'd0);
      check({tag, "_busy"},  128'(busy), 128'd0);
      check({tag, "_done"},  128'(done), 128'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t hold;
      rst = 1'b1; start = 1'b0; rk_ready = 1'b1; key = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      tick();

      // FIPS-197 vector, constant ready; key scrambled while busy
      key = FIPS_KEY; start = 1'b1;
      tick();
      start = 1'b0;
      key = {$urandom, $urandom, $urandom, $urandom};
      check("r0_valid", {rk_valid, round_num}, {1'b1, 4'd0});
      wait_done(200);

      // Back-to-back restart in the done cycle
      key = 128'h0f0e0d0c_0b0a0908_07060504_03020100; start = 1'b1;
      tick();
      start = 1'b0;
      check("b2b_valid", {rk_valid, round_num}, {1'b1, 4'd0});
      check("fips_r0", cap[0], FIPS_KEY);
      check("fips_r1", cap[1], FIPS_R1);
      check("fips_r10", cap[10], FIPS_R10);
      check("run1_accepts", 128'(accepts), 128'd11);
      check("run1_done_cnt", 128'(done_cnt), 128'd1);
      accepts = 0; done_cnt = 0;

      // Backpressure at round 3
      wait_round(4'd3, 100);
      rk_ready = 1'b0;
      hold = (sb.size() > 0) ? sb[0] : '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_rk", round_key, hold.rk);
         check("bp_rn", 128'(round_num), 128'd3);
         check("bp_valid", 128'(rk_valid), 128'd1);
      end
      @(posedge clk); #1;
      rk_ready = 1'b1;

      // Start with a different key while busy must be ignored
      wait_round(4'd5, 100);
      key = ~key; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(200);
      tick();
      check("run2_accepts", 128'(accepts), 128'd11);
      check("run2_done_cnt", 128'(done_cnt), 128'd1);
      check("run2_sb_drained", 128'(sb.size()), 128'd0);
      accepts = 0; done_cnt = 0;

      // Reset during SUB of round 7
      key = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
      tick();
      start = 1'b0;
      wait_round(4'd6, 100);
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      check_zero_outputs("abort");
      tick();
      tick();
      rst = 1'b0;
      repeat (20) tick();
      check("abort_no_done", 128'(done_cnt), 128'd0);
      accepts = 0;

      // All-zero key after abort restarts from round 0
      key = '0; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(200);
      tick();
      check("zero_r1", cap[1], ZERO_R1);
      check("run4_accepts", 128'(accepts), 128'd11);
      check("run4_done_cnt", 128'(done_cnt), 128'd1);
      check("sb_final", 128'(sb.size()), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
